// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmitter.
//   DataWidth          - bits per character (8)
//   ClksPerBitDefault  - default clock cycles per serial bit (100 MHz clk, 9600 baud)
//   uart_state_e       - transmitter FSM state encoding
//   even_parity()      - XOR reduction used for the optional parity bit
// Build option: define UART_TX_PARITY_EN to add the StParity state (8E1 frames);
// left undefined, frames are 8N1 and no parity state exists.
package uart_pkg;

    localparam int unsigned DataWidth         = 8;
    localparam int unsigned ClksPerBitDefault = 10416;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop  = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [DataWidth-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period timer for the UART transmitter.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   restart_i  - (re)load the down-counter and start timing a new bit
//   short_i    - with restart_i, time one cycle less than a full bit
//   bit_done_o - one-cycle pulse in the last cycle of the timed bit
// Parameter CLKS_PER_BIT (2..65535) sets the full bit length in cycles.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart_i,
    input  logic short_i,
    output logic bit_done_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] LoadFull  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] LoadShort = CntW'(CLKS_PER_BIT - 2);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (restart_i) begin
            cnt_d = short_i ? LoadShort : LoadFull;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // Gated by run_q so the idle counter (parked at 0) never reports a bit end.
    assign bit_done_o = run_q & (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, LSB first, one start and one stop bit.
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset; aborts any frame, line goes high
//   ena        - enable; gates acceptance of new bytes only
//   tx_data    - byte to send, sampled on acceptance
//   tx_valid   - tx_data holds a byte to send
//   tx_ready   - a byte can be accepted this cycle (idle and enabled)
//   tx_busy    - a frame is in progress
//   serial_out - UART line, idle high
// Build option: define UART_TX_PARITY_EN for an even-parity bit after the data bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [DataWidth-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 serial_out
);

    localparam int unsigned IdxW = $clog2(DataWidth);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DataWidth - 1);

    uart_state_e          state_q;
    logic                 armed_q;
    logic [DataWidth-1:0] shift_q;
    logic [IdxW-1:0]      bit_idx_q;
    logic                 serial_q;
    logic                 busy_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic accept;
    logic bit_done;
    logic timing;
    logic restart;
    logic short_bit;

    // armed_q keeps tx_ready low during reset and until the first edge after release.
    assign tx_ready = armed_q & (state_q == StIdle) & ena;
    assign accept   = tx_ready & tx_valid;

    always_comb begin
        timing = 1'b0;
        unique case (state_q)
            StStart, StData: timing = 1'b1;
`ifdef UART_TX_PARITY_EN
            StParity:        timing = 1'b1;
`endif
            default:         timing = 1'b0;
        endcase
    end

    assign restart = accept | (bit_done & timing);

    // The stop bit is timed one cycle short: its final high cycle is spent in
    // StIdle, where the next byte can already be accepted, so back-to-back
    // frames leave no gap beyond a full-length stop bit.
`ifdef UART_TX_PARITY_EN
    assign short_bit = bit_done & (state_q == StParity);
`else
    assign short_bit = bit_done & (state_q == StData) & (bit_idx_q == LastIdx);
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (restart),
        .short_i   (short_bit),
        .bit_done_o(bit_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            armed_q   <= 1'b0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            armed_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        shift_q  <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_q <= even_parity(tx_data);
`endif
                        serial_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        serial_q  <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        if (bit_idx_q == LastIdx) begin
`ifdef UART_TX_PARITY_EN
                            serial_q <= parity_q;
                            state_q  <= StParity;
`else
                            serial_q <= 1'b1;
                            state_q  <= StStop;
`endif
                        end else begin
                            serial_q  <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_done) begin
                        serial_q <= 1'b1;
                        state_q  <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (bit_done) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign serial_out = serial_q;
    assign tx_busy    = busy_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416, clock cycles per serial bit (100 MHz clk, 9600 baud); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ena  input  1  enable; gates acceptance of new bytes only.
REQ-005 SHALL have port tx_data  input  8  byte to transmit; sampled only on acceptance.
REQ-006 SHALL have port tx_valid  input  1  tx_data holds a byte to send.
REQ-007 SHALL have port tx_ready  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port tx_busy  output  1  a frame is in progress.
REQ-009 SHALL have port serial_out  output  1  UART line; idle high.

Function
REQ-010 SHALL implement states IDLE, START, DATA, PARITY (only when the parity feature is compiled in) and STOP.
REQ-011 SHALL drive tx_ready = 1 exactly when state is IDLE and ena = 1.
REQ-012 SHALL accept a byte on a rising edge where tx_valid = 1 and tx_ready = 1, latch tx_data into a shift register, and enter START.
REQ-013 SHALL ignore tx_data and tx_valid changes after acceptance until the next acceptance.
REQ-014 SHALL drive serial_out low starting in the cycle after the accepting edge; latency from acceptance to the start-bit edge is exactly 1 cycle.
REQ-015 SHALL hold each bit (start, 8 data, optional parity, stop) on serial_out for exactly CLKS_PER_BIT cycles.
REQ-016 SHALL transmit data bits LSB first (bit 0 immediately after the start bit).
REQ-017 SHALL drive serial_out high for the stop bit, then return to IDLE.
REQ-018 SHALL keep the bit counter width at $clog2(CLKS_PER_BIT) and count down to 0; the counter SHALL reload on every bit transition with no extra cycle.
REQ-019 SHALL keep serial_out high in IDLE.
REQ-020 SHALL drive tx_busy = 1 in every state except IDLE.
REQ-021 SHALL support back-to-back frames: with tx_valid and ena held high, successive acceptance edges SHALL be exactly 10*CLKS_PER_BIT cycles apart (11*CLKS_PER_BIT with parity), with no idle gap beyond the stop bit.
REQ-022 SHALL, when ena falls mid-frame, complete the current frame unchanged and then remain in IDLE with tx_ready = 0.
REQ-023 SHALL give the same result as REQ-012 when ena and tx_valid rise in the same cycle.

Reset
REQ-024 SHALL, while rst_n = 0, force state IDLE, serial_out = 1, tx_ready = 0, tx_busy = 0, the counters to 0 and the shift register to 0, independent of clk.
REQ-025 SHALL, on reset asserted mid-frame, abort the frame immediately with serial_out high; the aborted byte SHALL NOT be resumed.
REQ-026 SHALL assert tx_ready on the first rising edge after rst_n deasserts, provided ena = 1.

Configuration
REQ-027 SHALL, when UART_TX_PARITY_EN is defined, send one even-parity bit (XOR of the 8 latched data bits) in state PARITY, between the last data bit and the stop bit.
REQ-028 SHALL, when UART_TX_PARITY_EN is undefined, contain no PARITY state or parity logic and send 8N1 frames.

Structure
REQ-029 SHALL take the state enumeration typedef, data width (8) and default CLKS_PER_BIT from the shared package uart_pkg.
REQ-030 SHALL place bit-period timing in one sub-module, uart_baud_cnt, which takes CLKS_PER_BIT, a restart input, and a bit_done pulse output.

Verification
REQ-031 SHALL cover a single byte: CLKS_PER_BIT = 4, send 8'hA5 -> serial_out sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, starting 1 cycle after acceptance.
REQ-032 SHALL cover back-to-back bytes: 8'h3C then 8'h7F with tx_valid held -> acceptance edges exactly 40 cycles apart (44 with parity), with no idle-high gap beyond the stop bit.
REQ-033 SHALL cover parity: with UART_TX_PARITY_EN defined, 8'hC1 -> parity bit 1; 8'h99 -> parity bit 0; frame length 44 cycles.
REQ-034 SHALL cover reset mid-frame: 8'hE7, assert rst_n low during data bit 3 -> serial_out = 1 within the same cycle; tx_busy = 0; after release, 8'h42 is sent correctly.
REQ-035 SHALL cover the ena gate: ena = 0 with tx_valid = 1 -> tx_ready = 0 and serial_out stays 1; ena dropped mid-frame of 8'hB8 -> frame completes, then no new acceptance.
REQ-036 SHALL cover the default rate: CLKS_PER_BIT = 10416, 8'h5D -> each bit 104160 ns at a 10 ns clk; a reference UART receiver decodes 8'h5D.
